// File: rtl/uart_tx_fifo_ctrl_pkg.sv
// uart_tx_fifo_ctrl_pkg: register map offsets, STATUS bit positions and the
// serialiser state type shared by the UART TX block.
package uart_tx_fifo_ctrl_pkg;

  localparam int UART_IO_BIT_DEFAULT  = 22;
  localparam int UART_SEL_BIT_DEFAULT = 8;

  // register offsets, addr[3:2]
  localparam logic [1:0] UART_REG_DATA   = 2'd0;
  localparam logic [1:0] UART_REG_STATUS = 2'd1;
  localparam logic [1:0] UART_REG_DIV    = 2'd2;

  // STATUS bit indices
  localparam int UART_ST_BUSY  = 0;
  localparam int UART_ST_FULL  = 1;
  localparam int UART_ST_EMPTY = 2;
  localparam int UART_ST_OVF   = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_tx_fifo_ctrl_fifo.sv
// uart_tx_fifo_ctrl_fifo: synchronous FIFO with a combinational head output.
// Push is ignored when full; the caller only pops when not empty.
module uart_tx_fifo_ctrl_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_CNT = LW'(DEPTH);
  localparam logic [LW-1:0] CNT_ONE  = LW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_level   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // storage array; no reset needed, contents qualified by the count
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // pointers wrap naturally at DEPTH (power of two); count tracks occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// uart_tx_fifo_ctrl: memory-mapped UART transmitter (8N1 / 8N2).
// Byte stores to DATA fill a TX FIFO; a baud-rate FSM serialises them.
// Optional macro UART_SIM_PRINT_EN echoes accepted bytes with $display for
// simulation logs; serial behaviour is identical with or without it.
//
// state    | meaning
// ST_IDLE  | line high, waiting for a byte in the FIFO
// ST_START | start bit (line low), one divisor period
// ST_DATA  | 8 data bits LSB first, one divisor period each
// ST_STOP  | line high for STOP_BITS divisor periods
module uart_tx_fifo_ctrl
  import uart_tx_fifo_ctrl_pkg::*;
#(
  parameter int IO_MEM_MAP_BIT   = UART_IO_BIT_DEFAULT,
  parameter int UART_MEM_MAP_BIT = UART_SEL_BIT_DEFAULT,
  parameter int FIFO_DEPTH       = 16,
  parameter int DIV_WIDTH        = 16,
  parameter int DEFAULT_DIV      = 868,
  parameter int STOP_BITS        = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_addr_i,
  input  logic        mem_rstrb_i,
  output logic [31:0] mem_rdata_o,
  input  logic [3:0]  mem_wmask_i,
  input  logic [31:0] mem_wdata_i,
  output logic        uart_tx_o,
  output logic        tx_irq_o
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);

  logic                 w_sel;
  logic [1:0]           w_reg;
  logic                 w_rd;
  logic                 w_push_req;
  logic                 w_div_wr;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic [LW-1:0]        w_fifo_level;
  logic [7:0]           w_fifo_rdata;
  logic [7:0]           w_level8;
  logic [31:0]          w_rd_val;
  logic                 w_unused;

  logic [DIV_WIDTH-1:0] r_div;
  logic                 r_ovf;
  logic [31:0]          r_rdata;

  uart_state_e          r_state, w_state_nxt;
  logic [DIV_WIDTH-1:0] r_baud, w_baud_nxt;
  logic [DIV_WIDTH-1:0] r_div_lat, w_div_lat_nxt;
  logic [2:0]           r_bit, w_bit_nxt;
  logic                 r_stop, w_stop_nxt;
  logic [7:0]           r_shift, w_shift_nxt;
  logic                 r_tx, w_tx_nxt;
  logic                 w_pop;
  logic                 w_start;
  logic                 w_baud_zero;

  assign w_sel      = mem_addr_i[IO_MEM_MAP_BIT] & mem_addr_i[UART_MEM_MAP_BIT];
  assign w_reg      = mem_addr_i[3:2];
  assign w_rd       = w_sel & mem_rstrb_i;
  assign w_push_req = w_sel & (w_reg == UART_REG_DATA) & mem_wmask_i[0];
  assign w_div_wr   = w_sel & (w_reg == UART_REG_DIV) & (mem_wmask_i[1:0] == 2'b11);
  assign w_level8   = 8'(w_fifo_level);
  assign w_unused   = ^{mem_addr_i, mem_wdata_i, mem_wmask_i};

  // the full check inside the FIFO uses the count before this cycle's pop,
  // so a push while full is dropped even if the FSM pops on the same edge
  uart_tx_fifo_ctrl_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push_req & ~w_fifo_full),
    .i_wdata (mem_wdata_i[7:0]),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_level (w_fifo_level)
  );

  // read-data mux for the addressed register
  always_comb begin
    w_rd_val = '0;
    case (w_reg)
      UART_REG_STATUS: begin
        w_rd_val[UART_ST_BUSY]  = (r_state != ST_IDLE);
        w_rd_val[UART_ST_FULL]  = w_fifo_full;
        w_rd_val[UART_ST_EMPTY] = w_fifo_empty;
        w_rd_val[UART_ST_OVF]   = r_ovf;
        w_rd_val[15:8]          = w_level8;
      end
      UART_REG_DIV:    w_rd_val[DIV_WIDTH-1:0] = r_div;
      default:         w_rd_val = '0;
    endcase
  end

  // register file: divisor, sticky overflow (new overflow beats the clear), registered read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div   <= DIV_RST;
      r_ovf   <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (w_div_wr) begin
        r_div <= (mem_wdata_i[DIV_WIDTH-1:0] == '0) ? DIV_ONE : mem_wdata_i[DIV_WIDTH-1:0];
      end
      if (w_push_req && w_fifo_full) begin
        r_ovf <= 1'b1;
      end else if (w_rd && (w_reg == UART_REG_STATUS)) begin
        r_ovf <= 1'b0;
      end
      r_rdata <= w_rd ? w_rd_val : '0;
    end
  end

  assign w_baud_zero = (r_baud == '0);

  // serialiser next-state: baud counter runs div-1..0 per bit, divisor latched per frame
  always_comb begin
    w_state_nxt   = r_state;
    w_baud_nxt    = r_baud;
    w_div_lat_nxt = r_div_lat;
    w_bit_nxt     = r_bit;
    w_stop_nxt    = r_stop;
    w_shift_nxt   = r_shift;
    w_tx_nxt      = r_tx;
    w_pop         = 1'b0;
    w_start       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) w_start = 1'b1;
      end
      ST_START: begin
        if (w_baud_zero) begin
          w_state_nxt = ST_DATA;
          w_tx_nxt    = r_shift[0];
          w_bit_nxt   = '0;
          w_baud_nxt  = r_div_lat - DIV_ONE;
        end else begin
          w_baud_nxt  = r_baud - DIV_ONE;
        end
      end
      ST_DATA: begin
        if (w_baud_zero) begin
          w_baud_nxt = r_div_lat - DIV_ONE;
          if (r_bit == 3'd7) begin
            w_state_nxt = ST_STOP;
            w_tx_nxt    = 1'b1;
            w_stop_nxt  = (STOP_BITS == 2);
          end else begin
            w_bit_nxt   = r_bit + 3'd1;
            w_shift_nxt = r_shift >> 1;
            w_tx_nxt    = r_shift[1];
          end
        end else begin
          w_baud_nxt = r_baud - DIV_ONE;
        end
      end
      ST_STOP: begin
        if (w_baud_zero) begin
          if (r_stop) begin
            w_stop_nxt = 1'b0;
            w_baud_nxt = r_div_lat - DIV_ONE;
          end else if (!w_fifo_empty) begin
            w_start = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_baud_nxt = r_baud - DIV_ONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // frame start, shared by IDLE and back-to-back STOP
    if (w_start) begin
      w_state_nxt   = ST_START;
      w_pop         = 1'b1;
      w_shift_nxt   = w_fifo_rdata;
      w_div_lat_nxt = r_div;
      w_baud_nxt    = r_div - DIV_ONE;
      w_tx_nxt      = 1'b0;
    end
  end

  // serialiser state register; the TX line is a flop so it cannot glitch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_baud    <= '0;
      r_div_lat <= DIV_RST;
      r_bit     <= '0;
      r_stop    <= 1'b0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_baud    <= w_baud_nxt;
      r_div_lat <= w_div_lat_nxt;
      r_bit     <= w_bit_nxt;
      r_stop    <= w_stop_nxt;
      r_shift   <= w_shift_nxt;
      r_tx      <= w_tx_nxt;
    end
  end

  assign uart_tx_o   = r_tx;
  assign tx_irq_o    = w_fifo_empty & (r_state == ST_IDLE);
  assign mem_rdata_o = r_rdata;

`ifdef UART_SIM_PRINT_EN
  // simulation log of every byte store, accepted or dropped
  always_ff @(posedge clk) begin
    if (rst_n && w_push_req) begin
      if (!w_fifo_full) $display("[%0t ps][UART]: %c", $time, mem_wdata_i[7:0]);
      else              $display("[UART] overflow");
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Directed bench for uart_tx_fifo_ctrl: a register-access vector table, then
// hand-written serial-frame sequences checked against a frame waveform model.
`timescale 1ns/1ps
module tb_uart_tx_fifo_ctrl;

  localparam logic [31:0] A_DATA = 32'h0040_0100;
  localparam logic [31:0] A_STAT = 32'h0040_0104;
  localparam logic [31:0] A_DIV  = 32'h0040_0108;
  localparam logic [31:0] A_RSV  = 32'h0040_010C;
  localparam int OP_W = 0;
  localparam int OP_R = 1;
  localparam int OP_I = 2;
  localparam int RN   = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr, wdata, rdata;
  logic        rstrb, tx, irq;
  logic [3:0]  wmask;
  logic [31:0] addr2, wdata2, rdata2;
  logic        rstrb2, tx2, irq2;
  logic [3:0]  wmask2;

  always #5 clk = ~clk;

  uart_tx_fifo_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .mem_addr_i(addr), .mem_rstrb_i(rstrb),
    .mem_rdata_o(rdata), .mem_wmask_i(wmask), .mem_wdata_i(wdata),
    .uart_tx_o(tx), .tx_irq_o(irq)
  );

  uart_tx_fifo_ctrl #(.STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .mem_addr_i(addr2), .mem_rstrb_i(rstrb2),
    .mem_rdata_o(rdata2), .mem_wmask_i(wmask2), .mem_wdata_i(wdata2),
    .uart_tx_o(tx2), .tx_irq_o(irq2)
  );

  int total;
  int bad;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // line recorder, one sample per falling edge
  logic rec_en, rec_clr;
  int   rec_n;
  logic rec_tx [RN];
  logic rec_irq[RN];
  logic rec_tx2[RN];
  logic rec_irq2[RN];

  always @(negedge clk) begin
    if (rec_clr) rec_n <= 0;
    else if (rec_en && rec_n < RN) begin
      rec_tx[rec_n]   <= tx;
      rec_irq[rec_n]  <= irq;
      rec_tx2[rec_n]  <= tx2;
      rec_irq2[rec_n] <= irq2;
      rec_n           <= rec_n + 1;
    end
  end

  task automatic rec_start();
    @(posedge clk); rec_en = 1'b0; rec_clr = 1'b1;
    @(posedge clk); rec_clr = 1'b0; rec_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic rec_stop();
    @(posedge clk); rec_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    addr = a; wdata = d; wmask = m;
    @(negedge clk);
    wmask = 4'h0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    addr = a; rstrb = 1'b1;
    @(negedge clk);
    rstrb = 1'b0;
    d = rdata;
  endtask

  task automatic bus2_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    addr2 = a; wdata2 = d; wmask2 = m;
    @(negedge clk);
    wmask2 = 4'h0;
  endtask

  // expected line waveform, one entry per clock
  logic exp_q[$];

  task automatic add_frame(input logic [7:0] b, input int div, input int sb);
    for (int i = 0; i < div; i++) exp_q.push_back(1'b0);
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < div; i++) exp_q.push_back(b[k]);
    for (int i = 0; i < sb * div; i++) exp_q.push_back(1'b1);
  endtask

  task automatic check_frames(input string name, input bit second);
    int f;
    int errs;
    int n;
    logic s;
    f = -1;
    errs = 0;
    n = exp_q.size();
    for (int i = 0; i < rec_n; i++) begin
      s = second ? rec_tx2[i] : rec_tx[i];
      if (s == 1'b0) begin f = i; break; end
    end
    check({name, "_start_found"}, 64'(f >= 0), 64'(1));
    for (int i = 0; i < n; i++) begin
      if (f < 0 || f + i >= rec_n) errs++;
      else begin
        s = second ? rec_tx2[f + i] : rec_tx[f + i];
        if (s !== exp_q[i]) errs++;
      end
    end
    check({name, "_wave_errs"}, 64'(errs), 64'(0));
    s = 1'bx;
    if (f >= 0 && f + n - 1 < rec_n) s = second ? rec_irq2[f + n - 1] : rec_irq[f + n - 1];
    check({name, "_irq_last_bit"}, 64'(s), 64'(0));
    s = 1'bx;
    if (f >= 0 && f + n < rec_n) s = second ? rec_irq2[f + n] : rec_irq[f + n];
    check({name, "_irq_after"}, 64'(s), 64'(1));
    s = 1'bx;
    if (f >= 0 && f + n < rec_n) s = second ? rec_tx2[f + n] : rec_tx[f + n];
    check({name, "_idle_after"}, 64'(s), 64'(1));
    exp_q.delete();
  endtask

  typedef struct {
    int          op;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
    logic [31:0] e;
    string       nm;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int op, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] m, input logic [31:0] e, input string nm);
    vec_t v;
    v.op = op; v.a = a; v.d = d; v.m = m; v.e = e; v.nm = nm;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    total = 0; bad = 0;
    rst_n = 1'b0; rec_en = 1'b0; rec_clr = 1'b0;
    addr = '0; wdata = '0; wmask = '0; rstrb = 1'b0;
    addr2 = '0; wdata2 = '0; wmask2 = '0; rstrb2 = 1'b0;

    vecs.push_back(mk(OP_R, A_STAT, 0, 4'h0, 32'h0000_0004, "rst_status"));
    vecs.push_back(mk(OP_R, A_DIV, 0, 4'h0, 32'd868, "rst_div"));
    vecs.push_back(mk(OP_R, A_DATA, 0, 4'h0, 32'h0, "data_reads_zero"));
    vecs.push_back(mk(OP_R, A_RSV, 0, 4'h0, 32'h0, "rsv_reads_zero"));
    vecs.push_back(mk(OP_W, A_DIV, 32'h0, 4'hF, 0, ""));
    vecs.push_back(mk(OP_R, A_DIV, 0, 4'h0, 32'd1, "div_zero_stored_one"));
    vecs.push_back(mk(OP_W, A_DIV, 32'h1234, 4'h1, 0, ""));
    vecs.push_back(mk(OP_R, A_DIV, 0, 4'h0, 32'd1, "div_partial_mask_ignored"));
    vecs.push_back(mk(OP_W, A_DIV, 32'hABCD_0007, 4'h3, 0, ""));
    vecs.push_back(mk(OP_R, A_DIV, 0, 4'h0, 32'd7, "div_write_low16"));
    vecs.push_back(mk(OP_I, 0, 0, 4'h0, 32'h0, "rdata_zero_no_read"));
    vecs.push_back(mk(OP_W, A_RSV, 32'hFFFF_FFFF, 4'hF, 0, ""));
    vecs.push_back(mk(OP_R, A_RSV, 0, 4'h0, 32'h0, "rsv_write_ignored"));
    vecs.push_back(mk(OP_W, A_DATA, 32'h41, 4'h2, 0, ""));
    vecs.push_back(mk(OP_R, A_STAT, 0, 4'h0, 32'h0000_0004, "data_no_byte0_no_push"));
    vecs.push_back(mk(OP_W, 32'h0000_0108, 32'h9, 4'hF, 0, ""));
    vecs.push_back(mk(OP_W, 32'h0040_0008, 32'h9, 4'hF, 0, ""));
    vecs.push_back(mk(OP_R, A_DIV, 0, 4'h0, 32'd7, "div_other_window_ignored"));
    vecs.push_back(mk(OP_R, 32'h0000_0104, 0, 4'h0, 32'h0, "read_not_io"));
    vecs.push_back(mk(OP_R, 32'h0040_0004, 0, 4'h0, 32'h0, "read_io_not_uart"));

    repeat (3) @(negedge clk);
    check("rst_tx_high", 64'(tx), 64'(1));
    check("rst_irq_high", 64'(irq), 64'(1));
    check("rst_rdata_zero", 64'(rdata), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      case (vecs[i].op)
        OP_W: bus_wr(vecs[i].a, vecs[i].d, vecs[i].m);
        OP_R: begin
          bus_rd(vecs[i].a, r);
          check(vecs[i].nm, 64'(r), 64'(vecs[i].e));
        end
        default: begin
          @(negedge clk);
          check(vecs[i].nm, 64'(rdata), 64'(vecs[i].e));
        end
      endcase
    end

    // single 0x55 frame at DIV=4: 40 clocks, irq returns high right after
    bus_wr(A_DIV, 32'd4, 4'hF);
    rec_start();
    bus_wr(A_DATA, 32'h55, 4'h1);
    repeat (50) @(negedge clk);
    rec_stop();
    add_frame(8'h55, 4, 1);
    check_frames("frame55", 1'b0);

    // three back-to-back frames at DIV=2, no idle gap between them
    bus_wr(A_DIV, 32'd2, 4'hF);
    rec_start();
    bus_wr(A_DATA, 32'h01, 4'h1);
    bus_wr(A_DATA, 32'h80, 4'h1);
    bus_wr(A_DATA, 32'hC3, 4'h1);
    repeat (75) @(negedge clk);
    rec_stop();
    add_frame(8'h01, 2, 1);
    add_frame(8'h80, 2, 1);
    add_frame(8'hC3, 2, 1);
    check_frames("b2b", 1'b0);

    // DIV changed during frame 1: frame 1 keeps 2, frame 2 uses 3
    rec_start();
    bus_wr(A_DATA, 32'h0F, 4'h1);
    bus_wr(A_DATA, 32'hF0, 4'h1);
    bus_wr(A_DIV, 32'd3, 4'hF);
    bus_rd(A_STAT, r);
    check("midframe_status_busy_lvl1", 64'(r), 64'(32'h0000_0101));
    bus_rd(A_DIV, r);
    check("midframe_div_new", 64'(r), 64'(32'd3));
    repeat (70) @(negedge clk);
    rec_stop();
    add_frame(8'h0F, 2, 1);
    add_frame(8'hF0, 3, 1);
    check_frames("divchg", 1'b0);

    // overflow: the first byte moves to the shifter, 16 more fill the FIFO, the next is dropped
    bus_wr(A_DIV, 32'd100, 4'hF);
    for (int i = 0; i < 17; i++) bus_wr(A_DATA, 32'h00, 4'h1);
    bus_wr(A_DATA, 32'hAA, 4'h1);
    bus_rd(A_STAT, r);
    check("ovf_status", 64'(r), 64'(32'h0000_100B));
    bus_rd(A_STAT, r);
    check("ovf_cleared_by_read", 64'(r), 64'(32'h0000_1003));

    // reset while a zero data bit is on the line
    repeat (120) @(negedge clk);
    check("pre_reset_data_bit_low", 64'(tx), 64'(0));
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset_tx_high", 64'(tx), 64'(1));
    check("mid_reset_irq_high", 64'(irq), 64'(1));
    check("mid_reset_rdata_zero", 64'(rdata), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus_rd(A_STAT, r);
    check("post_reset_status", 64'(r), 64'(32'h0000_0004));
    bus_rd(A_DIV, r);
    check("post_reset_div", 64'(r), 64'(32'd868));

    // two-stop-bit instance: 0xFF at DIV=3 is a 33-clock frame
    bus2_wr(A_DIV, 32'd3, 4'hF);
    rec_start();
    bus2_wr(A_DATA, 32'hFF, 4'h1);
    repeat (45) @(negedge clk);
    rec_stop();
    add_frame(8'hFF, 3, 2);
    check_frames("stop2", 1'b1);
    check("stop2_rdata_idle", 64'(rdata2), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
